// File: rtl/dbus_uart_tx.sv
// Memory-mapped UART transmitter on the dBus peripheral region.
// Software-written bytes are queued in a TX FIFO and sent as 8N1 frames on txd.
module dbus_uart_tx #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic        cmd_wr,
  input  logic [3:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic [31:0] rsp_rdata,
  output logic        txd
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]      fifoMem [FIFO_DEPTH];
  logic [PtrW-1:0] wrPtr, rdPtr;
  logic [CntW-1:0] count;
  logic            full, empty;
  logic            wrCmd, rdCmd, dataWr, push, pop;
  logic            overflow;
  logic [15:0]     divisor, bitLen, baudCnt;
  logic [1:0]      state;
  logic [7:0]      shreg, head;
  logic [2:0]      bitIdx;
  logic            bitEnd;
  logic [31:0]     countExt;
  logic [7:0]      level;
  logic [31:0]     statusWord, readMux;
  logic            unusedBits;

  assign unusedBits = ^{cmd_addr[1:0], cmd_wdata[31:16]};

  assign wrCmd  = cmd_valid & cmd_wr;
  assign rdCmd  = cmd_valid & ~cmd_wr;
  assign full   = (count == FullCnt);
  assign empty  = (count == '0);
  assign dataWr = wrCmd && (cmd_addr[3:2] == ADDR_DATA);
  // A write into a full FIFO is dropped even if a pop frees a slot on the same edge.
  assign push   = dataWr && !full;
  assign bitEnd = (baudCnt == 16'd0);
  assign pop    = !empty && ((state == IDLE) || ((state == STOP) && bitEnd));
  assign head   = fifoMem[rdPtr];

  assign countExt   = 32'(count);
  assign level      = (countExt > 32'd255) ? 8'hFF : countExt[7:0];
  assign statusWord = {16'h0, level, 4'h0, overflow, (state != IDLE), empty, full};

  always_comb begin
    readMux = 32'h0;
    case (cmd_addr[3:2])
      ADDR_STATUS: readMux = statusWord;
      ADDR_DIV:    readMux = {16'h0, divisor};
      default:     readMux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr] <= cmd_wdata[7:0];
    end
  end

  // Bus side: read data, control registers and FIFO bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_rdata <= 32'h0;
      overflow  <= 1'b0;
      divisor   <= DIV_RESET;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
    end else begin
      if (rdCmd) begin
        rsp_rdata <= readMux;
      end
      if (dataWr && full) begin
        overflow <= 1'b1;
      end else if (wrCmd && (cmd_addr[3:2] == ADDR_STATUS) && cmd_wdata[3]) begin
        overflow <= 1'b0;
      end
      if (wrCmd && (cmd_addr[3:2] == ADDR_DIV)) begin
        divisor <= (cmd_wdata[15:0] == 16'd0) ? 16'd1 : cmd_wdata[15:0];
      end
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Serialiser: divisor is latched into bitLen at every pop so mid-frame writes wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      txd     <= 1'b1;
      shreg   <= 8'h0;
      bitLen  <= DIV_RESET;
      baudCnt <= 16'd0;
      bitIdx  <= 3'd0;
    end else if (state == IDLE) begin
      if (pop) begin
        shreg   <= head;
        bitLen  <= divisor;
        baudCnt <= divisor - 16'd1;
        txd     <= 1'b0;
        state   <= START;
      end
    end else if (!bitEnd) begin
      baudCnt <= baudCnt - 16'd1;
    end else begin
      baudCnt <= bitLen - 16'd1;
      case (state)
        START: begin
          txd    <= shreg[0];
          bitIdx <= 3'd0;
          state  <= DATA;
        end
        DATA: begin
          if (bitIdx == 3'd7) begin
            txd   <= 1'b1;
            state <= STOP;
          end else begin
            shreg  <= shreg >> 1;
            txd    <= shreg[1];
            bitIdx <= bitIdx + 3'd1;
          end
        end
        default: begin
          if (pop) begin
            shreg   <= head;
            bitLen  <= divisor;
            baudCnt <= divisor - 16'd1;
            txd     <= 1'b0;
            state   <= START;
          end else begin
            txd   <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Scoreboarded bench for dbus_uart_tx: queued expected frames are checked bit by bit
// against txd, and register reads are checked against hand-derived values.
module tb_dbus_uart_tx;

  localparam logic [3:0] A_DATA = 4'h0;
  localparam logic [3:0] A_STAT = 4'h4;
  localparam logic [3:0] A_DIV  = 4'h8;
  localparam logic [3:0] A_RSV  = 4'hC;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_wr = 1'b0;
  logic [3:0]  cmd_addr = 4'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic [31:0] rsp_rdata;
  logic        txd;

  dbus_uart_tx #(
    .FIFO_DEPTH(4),
    .DIV_RESET (16'd434)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_wr   (cmd_wr),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_rdata(rsp_rdata),
    .txd      (txd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    int unsigned len;
  } exp_t;

  exp_t expQ[$];
  int   startQ[$];
  int   nChecks = 0;
  int   nPass = 0;
  bit   monEn = 1'b0;
  bit   monBusy = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      nPass++;
    end
  endtask

  task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
  endtask

  task automatic busRead(input logic [3:0] a, output logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_wr    = 1'b0;
    cmd_addr  = a;
    @(negedge clk);
    d = rsp_rdata;
    cmd_valid = 1'b0;
  endtask

  task automatic writeData(input logic [7:0] d, input int unsigned len, input bit accept);
    exp_t e;
    busWrite(A_DATA, {24'h0, d});
    if (accept) begin
      e.data = d;
      e.len  = len;
      expQ.push_back(e);
    end
  endtask

  task automatic waitDrain(input int budget);
    int i;
    for (i = 0; i < budget && (expQ.size() != 0 || monBusy); i++) @(negedge clk);
    if (i >= budget) checkVal("drain_timeout", 32'(expQ.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Frame monitor: every sample of every bit must hold the expected level.
  logic [7:0]  monData;
  int unsigned monLen;
  logic        monLvl, monObs;
  bit          monBad;
  always begin
    @(negedge clk);
    if (monEn && txd === 1'b0) begin
      if (expQ.size() == 0) begin
        checkVal("unexpected_frame", 32'd1, 32'd0);
        for (int i = 0; i < 2000 && txd === 1'b0; i++) @(negedge clk);
      end else begin
        exp_t e;
        monBusy = 1'b1;
        e = expQ.pop_front();
        monData = e.data;
        monLen = e.len;
        startQ.push_back(cyc);
        for (int b = 0; b < 10; b++) begin
          monLvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : monData[b-1];
          monBad = 1'b0;
          monObs = monLvl;
          for (int k = 0; k < int'(monLen); k++) begin
            if (!(b == 0 && k == 0)) @(negedge clk);
            if (txd !== monLvl && !monBad) begin
              monBad = 1'b1;
              monObs = txd;
            end
          end
          checkVal($sformatf("frame_%02h_bit%0d", monData, b), {31'h0, monObs},
                   {31'h0, monLvl});
        end
        monBusy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          wrCyc;

    // Power-on reset.
    repeat (3) @(negedge clk);
    checkVal("por_txd", {31'h0, txd}, 32'd1);
    checkVal("por_rdata", rsp_rdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Start a frame of 0x00, then reset asynchronously in the middle of it.
    busWrite(A_DIV, 32'd4);
    busRead(A_DIV, rd);
    checkVal("div_rd_4", rd, 32'd4);
    busWrite(A_DATA, 32'h00);
    repeat (10) @(negedge clk);
    checkVal("txd_mid_frame", {31'h0, txd}, 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 checkVal("txd_async_reset", {31'h0, txd}, 32'd1);
    checkVal("rdata_async_reset", rsp_rdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    busRead(A_STAT, rd);
    checkVal("status_after_reset", rd, 32'h0000_0002);
    busRead(A_DIV, rd);
    checkVal("div_after_reset", rd, 32'd434);
    monEn = 1'b1;
    repeat (40) @(negedge clk);
    busRead(A_STAT, rd);
    checkVal("no_resume_status", rd, 32'h0000_0002);

    // Register map corners.
    busWrite(A_RSV, 32'hFFFF_FFFF);
    busRead(A_RSV, rd);
    checkVal("reserved_rd", rd, 32'h0);
    busRead(A_DIV, rd);
    checkVal("reserved_wr_ignored", rd, 32'd434);
    busRead(A_DATA, rd);
    checkVal("data_rd_zero", rd, 32'h0);

    // 0x55 at divisor 4: start one edge after the write, busy clears at E+41.
    busWrite(A_DIV, 32'd4);
    startQ.delete();
    writeData(8'h55, 4, 1'b1);
    wrCyc = cyc;
    repeat (40) @(negedge clk);
    busRead(A_STAT, rd);
    checkVal("busy_at_e41", rd & 32'h4, 32'h4);
    busRead(A_STAT, rd);
    checkVal("busy_at_e42", rd, 32'h0000_0002);
    waitDrain(200);
    checkVal("start_count_55", 32'(startQ.size()), 32'd1);
    if (startQ.size() > 0) checkVal("start_latency", 32'(startQ[0] - wrCyc), 32'd1);

    // Back-to-back frames at divisor 2.
    busWrite(A_DIV, 32'd2);
    startQ.delete();
    writeData(8'hA5, 2, 1'b1);
    writeData(8'h3C, 2, 1'b1);
    busRead(A_STAT, rd);
    checkVal("level_after_pop1", rd, 32'h0000_0104);
    repeat (19) @(negedge clk);
    busRead(A_STAT, rd);
    checkVal("empty_after_pop2", rd, 32'h0000_0006);
    waitDrain(200);
    checkVal("start_count_b2b", 32'(startQ.size()), 32'd2);
    if (startQ.size() > 1) checkVal("b2b_gap", 32'(startQ[1] - startQ[0]), 32'd20);

    // Overflow: one popped, four queued, sixth dropped.
    busWrite(A_DIV, 32'd100);
    for (int i = 1; i <= 6; i++) writeData(8'(i), 100, i != 6);
    busRead(A_STAT, rd);
    checkVal("status_full_ovf", rd, 32'h0000_040D);
    busWrite(A_STAT, 32'h8);
    busRead(A_STAT, rd);
    checkVal("status_ovf_clear", rd, 32'h0000_0405);
    waitDrain(6000);

    // Divisor 0 is stored as 1.
    busWrite(A_DIV, 32'd0);
    busRead(A_DIV, rd);
    checkVal("div_zero_as_one", rd, 32'd1);
    writeData(8'hFF, 1, 1'b1);
    waitDrain(100);

    // Divisor change mid-frame only affects the next pop.
    busWrite(A_DIV, 32'd4);
    startQ.delete();
    writeData(8'h0F, 4, 1'b1);
    writeData(8'hF0, 8, 1'b1);
    busWrite(A_DIV, 32'd8);
    waitDrain(400);
    checkVal("start_count_div", 32'(startQ.size()), 32'd2);
    if (startQ.size() > 1) checkVal("div_change_gap", 32'(startQ[1] - startQ[0]), 32'd40);
    busRead(A_STAT, rd);
    checkVal("final_status", rd, 32'h0000_0002);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
